// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// The datapath drives the decode/execute/memory status and consumes enables and flushes.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       id_r0_addr;
    logic [3:0]       id_r1_addr;
    logic             id_r0_read;
    logic             id_r1_read;
    logic             id_call;
    logic             id_halt;
    logic             ex_mem_read;
    logic [3:0]       ex_rd;
    logic             mem_branch_taken;
    logic             wb_ret;
    logic             dmem_ready;
    logic             mem_access;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_r0_addr, id_r1_addr, id_r0_read, id_r1_read, id_call, id_halt,
               ex_mem_read, ex_rd, mem_branch_taken, wb_ret, dmem_ready, mem_access,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halted, stall_count
    );

    modport slave (
        input  id_r0_addr, id_r1_addr, id_r0_read, id_r1_read, id_call, id_halt,
               ex_mem_read, ex_rd, mem_branch_taken, wb_ret, dmem_ready, mem_access,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halted, stall_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: prioritised hazard and redirect
// handling, the halt-drain FSM, and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.slave   bus
);

    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush;
    logic mem_wait, redirect, load_use, drain_last;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign mem_wait   = bus.mem_access && !bus.dmem_ready;
    assign redirect   = bus.wb_ret || bus.mem_branch_taken;
    assign load_use   = bus.ex_mem_read &&
                        ((bus.id_r0_read && (bus.id_r0_addr == bus.ex_rd)) ||
                         (bus.id_r1_read && (bus.id_r1_addr == bus.ex_rd)));
    assign drain_last = (drain_cnt_q == DW'(DRAIN_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;

        if (rst) begin
            pc_en       = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = RUN;
            drain_cnt_d = '0;
        end else if (state_q == HALT) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (mem_wait) begin
            // Whole pipe frozen, drain progress included.
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (redirect) begin
            // An older redirect proves any draining HLT was wrong-path.
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = RUN;
            drain_cnt_d = '0;
        end else if (state_q == DRAIN) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            if (drain_last) begin
                state_d     = HALT;
                drain_cnt_d = '0;
            end else begin
                drain_cnt_d = drain_cnt_q + DW'(1);
            end
        end else if (bus.id_call) begin
            ifid_flush = 1'b1;
        end else if (bus.id_halt) begin
            state_d     = DRAIN;
            drain_cnt_d = '0;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (state_q != HALT)) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.idex_en     = idex_en;
    assign bus.exmem_en    = exmem_en;
    assign bus.memwb_en    = memwb_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_flush = exmem_flush;
    assign bus.halted      = (state_q == HALT);
    assign bus.stall_count = stall_cnt_q;

endmodule
